// File: rtl/sel_unit_pipe.sv
// rtl/sel_unit_pipe.sv - registered sum-selection stage for the speculative carry-select adder
module sel_unit_pipe #(
    parameter int BLK_W   = 4,
    parameter int N_BLK   = 4,
    parameter int CORRECT = 1,
    parameter int ERR_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLK_W*N_BLK-1:0] s0_bus,
    input  logic [BLK_W*N_BLK-1:0] s1_bus,
    input  logic [N_BLK-1:0]       c0_bus,
    input  logic [N_BLK-1:0]       c1_bus,
    input  logic [N_BLK-1:0]       spec_sel,
    input  logic                   cin,
    output logic [BLK_W*N_BLK-1:0] sum,
    output logic                   cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_err,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int SUM_W = BLK_W * N_BLK;
    localparam bit EXACT = (CORRECT != 0);

    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] FIX = 1'b1;

    // Ripple the true block carries: block i takes carry-in from block i-1's chosen carry-out.
    function automatic logic [N_BLK-1:0] exact_sel(input logic [N_BLK-1:0] c0,
                                                    input logic [N_BLK-1:0] c1,
                                                    input logic             ci);
        logic [N_BLK-1:0] e;
        e    = '0;
        e[0] = ci;
        for (int i = 1; i < N_BLK; i++) begin
            e[i] = e[i-1] ? c1[i-1] : c0[i-1];
        end
        return e;
    endfunction

    // Per-block pick between the carry-in-0 and carry-in-1 sums; no arithmetic here.
    function automatic logic [SUM_W-1:0] pick_sum(input logic [SUM_W-1:0] a,
                                                   input logic [SUM_W-1:0] b,
                                                   input logic [N_BLK-1:0] sel);
        logic [SUM_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_BLK; i++) begin
            r[i*BLK_W +: BLK_W] = sel[i] ? b[i*BLK_W +: BLK_W] : a[i*BLK_W +: BLK_W];
        end
        return r;
    endfunction

    function automatic logic pick_cout(input logic [N_BLK-1:0] c0,
                                       input logic [N_BLK-1:0] c1,
                                       input logic [N_BLK-1:0] sel);
        return sel[N_BLK-1] ? c1[N_BLK-1] : c0[N_BLK-1];
    endfunction

    logic [0:0]       state;
    logic [SUM_W-1:0] h_s0;
    logic [SUM_W-1:0] h_s1;
    logic [N_BLK-1:0] h_c0;
    logic [N_BLK-1:0] h_c1;
    logic             h_cin;

    logic [N_BLK-1:0] ssel;
    logic [N_BLK-1:0] esel;
    logic [N_BLK-1:0] h_esel;
    logic             mis;
    logic             accept;
    logic [SUM_W-1:0] run_sum;
    logic             run_cout;
    logic [SUM_W-1:0] fix_sum;
    logic             fix_cout;

    // Select vectors and candidate results for the direct path and the correction path.
    always_comb begin
        ssel     = spec_sel;
        ssel[0]  = cin;
        esel     = exact_sel(c0_bus, c1_bus, cin);
        mis      = (ssel != esel);
        in_ready = (state == RUN) && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        // Without a mismatch ssel equals esel, so the direct path always uses ssel.
        run_sum  = pick_sum(s0_bus, s1_bus, ssel);
        run_cout = pick_cout(c0_bus, c1_bus, ssel);
        h_esel   = exact_sel(h_c0, h_c1, h_cin);
        fix_sum  = pick_sum(h_s0, h_s1, h_esel);
        fix_cout = pick_cout(h_c0, h_c1, h_esel);
    end

    // RUN/FIX control, output register and hold registers for the correction cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            h_s0      <= '0;
            h_s1      <= '0;
            h_c0      <= '0;
            h_c1      <= '0;
            h_cin     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (mis && EXACT) begin
                            // Output is free or draining now, so the FIX load cannot clobber it.
                            h_s0      <= s0_bus;
                            h_s1      <= s1_bus;
                            h_c0      <= c0_bus;
                            h_c1      <= c1_bus;
                            h_cin     <= cin;
                            out_valid <= 1'b0;
                            state     <= FIX;
                        end else begin
                            sum       <= run_sum;
                            cout      <= run_cout;
                            out_err   <= mis;
                            out_valid <= 1'b1;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                FIX: begin
                    sum       <= fix_sum;
                    cout      <= fix_cout;
                    out_err   <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating count of accepted mis-speculated transactions, in either mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && mis && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: doc/sel_unit_pipe.md
Name: sel_unit_pipe

Overview:
Parametrised, registered sum-selection stage for the speculative carry-select adder. It takes the two candidate sums from each block (carry-in 0 and carry-in 1), the per-block carries and a per-block speculative select. It outputs the selected sum and carry-out through a valid/ready handshake. In exact mode it detects mis-speculation and spends one extra correction cycle to emit the exact sum; in approximate mode it emits the speculative sum and flags the error. It sits between the block adders and the result register of the adder datapath.

Parameters:
BLK_W, 4, bits per carry-select block
N_BLK, 4, number of blocks; sum width is SUM_W = BLK_W*N_BLK
CORRECT, 1, 1 = exact mode (recover on mis-speculation), 0 = approximate mode (flag only)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  stage can accept input
s0_bus  in  SUM_W  block sums assuming block carry-in 0; block i = bits [i*BLK_W +: BLK_W]
s1_bus  in  SUM_W  block sums assuming block carry-in 1
c0_bus  in  N_BLK  block carry-outs assuming carry-in 0
c1_bus  in  N_BLK  block carry-outs assuming carry-in 1
spec_sel  in  N_BLK  speculative select per block; bit 0 ignored
cin  in  1  adder carry-in
sum  out  SUM_W  selected sum
cout  out  1  selected carry-out
out_valid  out  1  sum/cout/out_err valid
out_ready  in  1  downstream accepts
out_err  out  1  transaction was mis-speculated
err_cnt  out  ERR_W  count of mis-speculated transactions, saturating

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: sum=0, cout=0, out_valid=0, out_err=0, err_cnt=0, state=RUN; all hold registers are 0.
- Accept: a transaction is accepted when in_valid && in_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Select vectors:
  - Effective speculative select: ssel[0]=cin, ssel[i]=spec_sel[i] for i>=1.
  - Exact select: esel[0]=cin, esel[i] = esel[i-1] ? c1[i-1] : c0[i-1].
- Mismatch: mis = (ssel != esel).
- Block sum: block i of the result = sel[i] ? s1 block i : s0 block i.
- Carry-out: cout = sel[N_BLK-1] ? c1[N_BLK-1] : c0[N_BLK-1], using the same select vector as the sum.
- State machine, states RUN and FIX:
  - RUN, accept, !mis: next cycle out_valid=1, sum/cout from esel (equal to ssel), out_err=0. Latency 1.
  - RUN, accept, mis, CORRECT=0: next cycle out_valid=1, sum/cout from ssel, out_err=1. Latency 1.
  - RUN, accept, mis, CORRECT=1: capture s0/s1/c0/c1/cin into hold registers and go to FIX. out_valid=0 in the next cycle, or drops to 0 if the previous result is consumed that cycle.
  - FIX: in_ready=0. After one cycle, load sum/cout from esel of the held operands, set out_valid=1 and out_err=1, and return to RUN. Latency 2.
  - FIX is only entered when the output register is free or being drained that cycle, so the FIX-cycle load never overwrites an unconsumed result.
- Output hold: while out_valid && !out_ready, sum, cout and out_err are held stable.
- Output clear: out_valid clears on handshake unless a new result loads in the same cycle.
- Error counter: err_cnt increments by 1 on each accepted transaction with mis=1, in both modes. It saturates at 2^ERR_W-1.
- Reset mid-operation: rst in FIX discards the held transaction. No output is produced for it; the reset values above apply.
- Width rules: no arithmetic on sums, selection only. N_BLK=1 degenerates to selection by cin, so mis is always 0.

Test Plan:
- No-mismatch case (BLK_W=4, N_BLK=4, CORRECT=1, out_ready=1):
  - Stimulus: s0=16'h1234, s1=16'h2345, c0=4'b0000, c1=4'b0000, spec_sel=4'b0000, cin=0.
  - Response: 1 cycle later out_valid=1, sum=16'h1234, cout=0, out_err=0, err_cnt=0.
- Mismatch, exact mode (CORRECT=1):
  - Stimulus: same sums, c0=4'b0001, c1=4'b1111, spec_sel=4'b0000, cin=0. This gives esel=4'b1110.
  - Response: in_ready=0 for 1 cycle; 2 cycles after accept sum=16'h2344, cout=1, out_err=1, err_cnt=1.
- Mismatch, approximate mode (CORRECT=0):
  - Stimulus: same as the previous scenario.
  - Response: 1 cycle later sum=16'h1234, cout=0, out_err=1, err_cnt=1, in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after the first result, with in_valid held high.
  - Response: sum stable, in_ready=0, exactly one transaction accepted until drain; no loss or duplication.
- Counter saturation (ERR_W=2):
  - Stimulus: 5 mis-speculated transactions.
  - Response: err_cnt sequence 1,2,3,3,3.
- Reset mid-operation:
  - Stimulus: assert rst during FIX.
  - Response: next cycle out_valid=0, err_cnt=0, in_ready=1; no output for the discarded transaction.
